// File: rtl/branch_pkg.sv
// Shared definitions for the fetch-side branch redirect logic and the EX comparator.
// Holds the redirect FSM state encoding, B-type funct3 codes and the default reset PC.
// No logic lives here; types and constants only.
package branch_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        HALT    = 2'd2
    } state_t;

    // B-type funct3 encodings, shared with the EX-stage comparator
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for branch statistics.
// Latency: count reflects an inc one cycle after it is sampled.
// No backpressure; the count simply sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc until every bit is set, then hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: sequential advance, EX-resolved redirects with IF/ID + ID/EX flush, misaligned-target trap.
// Latency: a take with imem_ready moves pc next cycle; otherwise one cycle after imem_ready in PENDING.
// Backpressure: imem_ready low holds pc; a redirect seen while imem is busy is parked in pending_pc.
module branch_redirect_unit
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             branch_taken,
    input  logic [31:0]      ex_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misaligned_trap,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        take;
    logic        misalign;
    logic        count_en;

    // A jump always redirects, even if the decoder also flagged it as a branch
    assign take     = ex_valid & (ex_is_jump | (ex_is_branch & branch_taken));
    assign misalign = take & (ex_target[1:0] != 2'b00);
    assign count_en = (state_q != HALT);

    // Next-state and next-pc selection; a redirect takes priority over stall
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        case (state_q)
            RUN: begin
                if (misalign) begin
                    state_d = HALT;
                end else if (take) begin
                    if (imem_ready) begin
                        pc_d = ex_target;
                    end else begin
                        pending_d = ex_target;
                        state_d   = PENDING;
                    end
                end else if (!stall && imem_ready) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            PENDING: begin
                if (misalign) begin
                    state_d = HALT;
                end else if (take) begin
                    // Youngest redirect wins, whether or not imem accepts it now
                    if (imem_ready) begin
                        pc_d    = ex_target;
                        state_d = RUN;
                    end else begin
                        pending_d = ex_target;
                    end
                end else if (imem_ready) begin
                    pc_d    = pending_q;
                    state_d = RUN;
                end
            end
            default: begin
                // HALT: frozen until reset
                state_d = HALT;
            end
        endcase
    end

    // State, pc and parked redirect registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (count_en & ex_valid & ex_is_branch),
        .count (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (count_en & ex_valid & ex_is_branch & branch_taken),
        .count (taken_count)
    );

    assign pc              = pc_q;
    assign misaligned_trap = (state_q == HALT);
    assign pc_plus4        = reset ? 32'd0 : (pc_q + 32'd4);
    assign flush_if_id     = !reset & take & (state_q != HALT);
    assign flush_id_ex     = !reset & take & (state_q != HALT);
    assign fetch_valid     = !reset & (state_q == RUN) & !take & imem_ready & !stall;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit with RESET_PC=0x100 and 4-bit counters.
// A reference model pushes the expected post-edge {pc, counters, trap} into a queue per cycle.
// Each scenario task pops and compares, and checks combinational outputs mid-cycle.
module tb_branch_redirect_unit;

    localparam int M_RUN  = 0;
    localparam int M_PEND = 1;
    localparam int M_HALT = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  bc;
        logic [3:0]  tc;
        logic        trap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, imem_ready, ex_valid, ex_is_branch, ex_is_jump, branch_taken;
    logic [31:0] ex_target;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, flush_if_id, flush_id_ex, misaligned_trap;
    logic [3:0]  branch_count, taken_count;

    int          errors = 0;
    int          checks = 0;

    exp_t        exp_q[$];
    exp_t        e, got;
    int          m_st;
    logic [31:0] m_pc, m_pend;
    logic [3:0]  m_bc, m_tc;
    logic        m_trap;

    branch_redirect_unit #(.RESET_PC(32'h100), .CNT_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .imem_ready      (imem_ready),
        .ex_valid        (ex_valid),
        .ex_is_branch    (ex_is_branch),
        .ex_is_jump      (ex_is_jump),
        .branch_taken    (branch_taken),
        .ex_target       (ex_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .misaligned_trap (misaligned_trap),
        .branch_count    (branch_count),
        .taken_count     (taken_count)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic st, input logic rdy, input logic v, input logic br,
                         input logic j, input logic tk, input logic [31:0] tgt);
        stall = st; imem_ready = rdy; ex_valid = v; ex_is_branch = br;
        ex_is_jump = j; branch_taken = tk; ex_target = tgt;
    endtask

    task automatic model_reset();
        m_st = M_RUN; m_pc = 32'h100; m_pend = 32'h0; m_bc = 4'h0; m_tc = 4'h0; m_trap = 1'b0;
    endtask

    // Reference model step for the current inputs, then clock the DUT
    task automatic advance();
        logic tk, mis;
        tk  = ex_valid & (ex_is_jump | (ex_is_branch & branch_taken));
        mis = tk & (ex_target[1:0] != 2'b00);
        if (m_st != M_HALT) begin
            if (ex_valid && ex_is_branch && m_bc != 4'hF) m_bc = m_bc + 4'd1;
            if (ex_valid && ex_is_branch && branch_taken && m_tc != 4'hF) m_tc = m_tc + 4'd1;
            if (mis) begin
                m_st = M_HALT; m_trap = 1'b1;
            end else if (tk) begin
                if (imem_ready) begin m_pc = ex_target; m_st = M_RUN; end
                else begin m_pend = ex_target; m_st = M_PEND; end
            end else if (m_st == M_RUN) begin
                if (!stall && imem_ready) m_pc = m_pc + 32'd4;
            end else if (imem_ready) begin
                m_pc = m_pend; m_st = M_RUN;
            end
        end
        exp_q.push_back('{pc: m_pc, bc: m_bc, tc: m_tc, trap: m_trap});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply(0, 1, 0, 0, 0, 0, 32'h0);
        reset = 1'b1;
        model_reset();
        #3;
        checks++;
        if ({pc, branch_count, taken_count, misaligned_trap} !== {32'h100, 4'h0, 4'h0, 1'b0}) begin
            errors++; $display("FAIL reset_state got pc=%h bc=%h tc=%h trap=%b exp pc=100 bc=0 tc=0 trap=0",
                               pc, branch_count, taken_count, misaligned_trap);
        end
        checks++;
        if ({fetch_valid, flush_if_id, flush_id_ex} !== 3'b000) begin
            errors++; $display("FAIL reset_comb got fv/fl1/fl2=%b%b%b exp 000", fetch_valid, flush_if_id, flush_id_ex);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (fetch_valid !== 1'b1) begin
                errors++; $display("FAIL seq_fetch_valid cyc%0d got %b exp 1", i, fetch_valid);
            end
            advance();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || pc_plus4 !== e.pc + 32'd4) begin
                errors++; $display("FAIL seq_pc cyc%0d got pc=%h pc4=%h exp pc=%h", i, pc, pc_plus4, e.pc);
            end
        end
        checks++;
        if (pc !== 32'h110) begin
            errors++; $display("FAIL seq_pc_final got %h exp 00000110", pc);
        end
    endtask

    task automatic test_redirect();
        apply(0, 1, 1, 0, 1, 0, 32'h200);
        advance();
        e = exp_q.pop_front();
        apply(0, 1, 1, 1, 0, 1, 32'h080);
        #2;
        checks++;
        if ({flush_if_id, flush_id_ex, fetch_valid} !== 3'b110) begin
            errors++; $display("FAIL redirect_comb got fl1/fl2/fv=%b%b%b exp 110", flush_if_id, flush_id_ex, fetch_valid);
        end
        advance();
        e = exp_q.pop_front();
        got = '{pc: pc, bc: branch_count, tc: taken_count, trap: misaligned_trap};
        checks++;
        if (got !== e || pc !== 32'h080 || branch_count !== 4'd1 || taken_count !== 4'd1) begin
            errors++; $display("FAIL redirect_state got %h exp %h", got, e);
        end
    endtask

    task automatic test_pending();
        apply(0, 0, 1, 0, 1, 0, 32'h300);
        #2;
        checks++;
        if ({flush_if_id, fetch_valid} !== 2'b10) begin
            errors++; $display("FAIL pending_take_comb got fl/fv=%b%b exp 10", flush_if_id, fetch_valid);
        end
        advance();
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            apply(0, (i == 2), 0, 0, 0, 0, 32'h0);
            #2;
            checks++;
            if ({flush_if_id, fetch_valid} !== 2'b00) begin
                errors++; $display("FAIL pending_wait_comb cyc%0d got fl/fv=%b%b exp 00", i, flush_if_id, fetch_valid);
            end
            advance();
            e = exp_q.pop_front();
            got = '{pc: pc, bc: branch_count, tc: taken_count, trap: misaligned_trap};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL pending_state cyc%0d got %h exp %h", i, got, e);
            end
        end
        checks++;
        if (pc !== 32'h300) begin
            errors++; $display("FAIL pending_target got %h exp 00000300", pc);
        end
    endtask

    task automatic test_stall();
        apply(1, 1, 1, 1, 0, 0, 32'h700);
        #2;
        checks++;
        if ({flush_if_id, flush_id_ex, fetch_valid} !== 3'b000) begin
            errors++; $display("FAIL stall_nt_comb got fl1/fl2/fv=%b%b%b exp 000", flush_if_id, flush_id_ex, fetch_valid);
        end
        advance();
        e = exp_q.pop_front();
        got = '{pc: pc, bc: branch_count, tc: taken_count, trap: misaligned_trap};
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL stall_nt_state got %h exp %h", got, e);
        end
        apply(1, 1, 1, 0, 1, 0, 32'h40);
        advance();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e.pc) begin
            errors++; $display("FAIL stall_take_pc got %h exp %h", pc, e.pc);
        end
    endtask

    task automatic test_pending_overwrite();
        apply(0, 0, 1, 0, 1, 0, 32'h500);
        advance();
        e = exp_q.pop_front();
        apply(0, 1, 1, 1, 0, 1, 32'h600);
        advance();
        e = exp_q.pop_front();
        got = '{pc: pc, bc: branch_count, tc: taken_count, trap: misaligned_trap};
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL pending_overwrite got %h exp %h", got, e);
        end
    endtask

    task automatic test_saturate_wrap();
        for (int i = 0; i < 20; i++) begin
            apply(0, 1, 1, 1, 0, 1, 32'h1000 + 32'(i) * 32'd4);
            advance();
            e = exp_q.pop_front();
            got = '{pc: pc, bc: branch_count, tc: taken_count, trap: misaligned_trap};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL saturate cyc%0d got %h exp %h", i, got, e);
            end
        end
        checks++;
        if ({branch_count, taken_count} !== 8'hFF) begin
            errors++; $display("FAIL saturate_final got bc=%h tc=%h exp F F", branch_count, taken_count);
        end
        apply(0, 1, 1, 0, 1, 0, 32'hFFFF_FFFC);
        advance();
        e = exp_q.pop_front();
        apply(0, 1, 0, 0, 0, 0, 32'h0);
        #2;
        checks++;
        if (pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL wrap_pc_plus4 got %h exp 00000000", pc_plus4);
        end
        advance();
        e = exp_q.pop_front();
        checks++;
        if (pc !== e.pc || pc !== 32'h0) begin
            errors++; $display("FAIL wrap_pc got %h exp %h", pc, e.pc);
        end
    endtask

    task automatic test_misalign();
        apply(0, 1, 1, 0, 1, 0, 32'h0000_0102);
        #2;
        checks++;
        if ({flush_if_id, fetch_valid} !== 2'b10) begin
            errors++; $display("FAIL misalign_comb got fl/fv=%b%b exp 10", flush_if_id, fetch_valid);
        end
        advance();
        e = exp_q.pop_front();
        got = '{pc: pc, bc: branch_count, tc: taken_count, trap: misaligned_trap};
        checks++;
        if (got !== e || misaligned_trap !== 1'b1) begin
            errors++; $display("FAIL misalign_state got %h exp %h", got, e);
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, (i != 0), 1, 0, 1, 32'h40);
            #2;
            checks++;
            if ({flush_if_id, fetch_valid} !== 2'b00) begin
                errors++; $display("FAIL halt_comb cyc%0d got fl/fv=%b%b exp 00", i, flush_if_id, fetch_valid);
            end
            advance();
            e = exp_q.pop_front();
            got = '{pc: pc, bc: branch_count, tc: taken_count, trap: misaligned_trap};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL halt_state cyc%0d got %h exp %h", i, got, e);
            end
        end
        apply(0, 1, 0, 0, 0, 0, 32'h0);
        reset = 1'b1;
        model_reset();
        #2;
        checks++;
        if ({pc, misaligned_trap, branch_count} !== {32'h100, 1'b0, 4'h0}) begin
            errors++; $display("FAIL halt_reset got pc=%h trap=%b bc=%h exp pc=100 trap=0 bc=0",
                               pc, misaligned_trap, branch_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        checks++;
        if (fetch_valid !== 1'b1) begin
            errors++; $display("FAIL post_reset_fetch got %b exp 1", fetch_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        test_reset();
        test_redirect();
        test_pending();
        test_stall();
        test_pending_overwrite();
        test_saturate_wrap();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Fetch-side consumer of the EX-stage branch decision in the RV32IM 5-stage pipeline. Holds the program counter and advances it sequentially. On a taken branch or jump resolved in EX, redirects fetch to the target and flushes the two younger pipeline stages. Also handles instruction-memory back-pressure, traps on misaligned targets, and keeps saturating branch statistics for performance checks.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of statistics counters
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  hazard-unit hold; freezes sequential PC advance
- imem_ready  in  1  instruction memory accepts a fetch this cycle
- ex_valid  in  1  EX-stage instruction is valid, not a bubble
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_is_jump  in  1  EX instruction is JAL/JALR
- branch_taken  in  1  comparator result for the EX branch
- ex_target  in  32  resolved target address from EX
- pc  out  32  current fetch address
- pc_plus4  out  32  pc + 4, modulo 2^32
- fetch_valid  out  1  fetch at pc is architecturally valid this cycle
- flush_if_id  out  1  squash IF/ID register
- flush_id_ex  out  1  squash ID/EX register
- misaligned_trap  out  1  sticky; target with ex_target[1:0] != 0 was taken
- branch_count  out  CNT_W  valid conditional branches seen, saturating
- taken_count  out  CNT_W  taken conditional branches, saturating

## Operation
- take = ex_valid & (ex_is_jump | (ex_is_branch & branch_taken)); misalign = take & (ex_target[1:0] != 2'b00).
- States: RUN, PENDING (redirect latched, waiting for imem_ready), HALT (trap).
- RUN:
  - take & !misalign & imem_ready: pc <= ex_target; stay in RUN.
  - take & !misalign & !imem_ready: pending_pc <= ex_target; go to PENDING.
  - no take: pc <= pc+4 if !stall & imem_ready; otherwise pc holds.
  - A redirect overrides stall.
- PENDING: pc holds. When imem_ready, pc <= pending_pc and go to RUN. A new take here overwrites pending_pc; if imem_ready is high in the same cycle, the new target wins.
- misalign in any non-HALT state: go to HALT and set misaligned_trap. pc is not updated. Exit HALT only by reset.
- Combinational outputs:
  - flush_if_id = flush_id_ex = take & (state != HALT).
  - fetch_valid = (state == RUN) & !take & imem_ready & !stall.
  - All combinational outputs are forced to 0 while reset is high.
- Counters: update in RUN and PENDING only.
  - branch_count increments on ex_valid & ex_is_branch.
  - taken_count increments on ex_valid & ex_is_branch & branch_taken.
  - Both hold at all-ones. ex_is_jump does not count.

## Timing
- Reset values: pc = RESET_PC, state = RUN, pending_pc = 0, misaligned_trap = 0, both counters 0. fetch_valid and both flush outputs are 0.
- Redirect latency:
  - take in cycle N with imem_ready: pc = ex_target in N+1.
  - Otherwise pc = target in the first cycle after imem_ready is seen high in PENDING.
- Flushes are high only in the take cycle; one cycle per take.
- Sequential wrap: pc 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Reset mid-PENDING discards pending_pc. Reset mid-HALT clears the trap.
- The unit does not qualify ex_is_branch against ex_is_jump; if both are high, the jump decides take.

## Structure
- Shared package branch_pkg holds:
  - state enum {RUN, PENDING, HALT}
  - B-type funct3 constants BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111, shared with the comparator
  - default RESET_PC
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instanced twice for the statistics counters.

## Test plan
- Reset RESET_PC=32'h100, imem_ready=1, no take, 4 cycles -> pc 100,104,108,10C,110; fetch_valid=1 after reset release.
- pc=32'h200, valid taken branch to 32'h080 with imem_ready=1 -> flushes=1 and fetch_valid=0 that cycle; pc=32'h080 next cycle; branch_count=1, taken_count=1.
- Taken jump to 32'h300 with imem_ready=0 for 3 cycles -> PENDING, pc frozen, fetch_valid=0; pc=32'h300 one cycle after imem_ready rises; counters unchanged.
- stall=1 while a not-taken branch is in EX -> pc holds, no flush; branch_count+1, taken_count unchanged. stall=1 with take to 32'h40 -> pc=32'h40 next cycle.
- Take to 32'h0000_0102 -> misaligned_trap=1, pc unchanged, fetch_valid=0 indefinitely; reset clears the trap and restores RESET_PC.
- CNT_W=4, 20 taken branches -> both counters saturate at 4'hF; pc=32'hFFFF_FFFC advances to 32'h0.
